opb_status_bank: RTL and testbench
==================================

# opb_status_bank

Parametrised OPB slave that makes C_NUM_CH user-side status words readable by the PowerPC. It replaces single-word simulink-to-PPC status registers on the OPB bus and adds per-channel capture strobes, a software freeze for coherent multi-word reads, 16-bit update counters and optional sticky bits. It runs on a single clock, so user logic must already be in the OPB_Clk domain.

## Interface
- C_BASEADDR, 32'h01080100, base of the 256-byte window
- C_HIGHADDR, 32'h010801FF, top of the window; C_HIGHADDR-C_BASEADDR+1 must equal 256
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_NUM_CH, 4, number of channels, 1..16
- C_DATA_WIDTH, 32, bits per channel, 1..32
- OPB_Clk  in  1  sole clock for bus and user side
- OPB_Rst_n  in  1  reset, asynchronous assert, active-low
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1=read, 0=write
- OPB_select  in  1  transfer in progress
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; zero when Sl_xferAck is low
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_in  in  [C_NUM_CH*C_DATA_WIDTH-1:0]  channel k occupies bits [k*C_DATA_WIDTH +: C_DATA_WIDTH]
- user_valid  in  [C_NUM_CH-1:0]  per-channel capture strobe

## Operation
- Register map uses word index w = OPB_ABus[24:29], which is offset bits [7:2].
  - w = 0..15: LIVE[k], read-only.
  - w = 16..31: STICKY[k], write-1-to-clear.
  - w = 32: CTRL. Bit 31 (LSB) is FREEZE, read/write.
  - w = 48..63: CNT[k], read-only.
- Indices with k >= C_NUM_CH, and every other index, read 0. Writes to them are ignored but still acknowledged.
- Values are right-aligned: channel LSB maps to Sl_DBus[31], and unused upper bits read 0.
- LIVE[k] loads user_data_in[k] when user_valid[k]=1 and FREEZE=0. While FREEZE=1, LIVE holds its value.
- CNT[k] is a 16-bit counter that wraps 0xFFFF->0. It increments on every user_valid[k] pulse regardless of FREEZE.
- Write data qualified by BE: a byte with BE=0 is unchanged in CTRL and not cleared in STICKY.
- Address hit means OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Ack FSM:
  - IDLE -> ACK on a hit.
  - ACK -> IDLE unconditionally.
  - Sl_xferAck=1 only in ACK.
  - A hit still present in the ACK cycle does not re-trigger. A hit in the following IDLE cycle starts a new transfer, so back-to-back transfers complete at most one every 2 cycles.
- Write side effects commit on the IDLE->ACK edge.

## Timing
- Read latency: Sl_xferAck and Sl_DBus are registered and valid exactly 1 cycle after the hit is sampled.
- Read data is the register value at the sampling edge. A capture in the same cycle is not visible until the next read.
- Reset, asynchronous, applies immediately to all state:
  - Sl_xferAck=0, Sl_DBus=0, FSM=IDLE.
  - LIVE=0, STICKY=0, CNT=0, FREEZE=0.
- Reset mid-transfer drops the ack. The master then times out.
- Simultaneous user_valid and W1C on the same STICKY bit: the set wins, so a bit set by new data stays 1.
- FREEZE written to 1 in cycle t: a user_valid in cycle t is still captured. Captures from t+1 onward are blocked.

## Configuration
- STATUS_BANK_STICKY_EN defined: STICKY[k] |= user_data_in[k] on each user_valid[k], independent of FREEZE, and is cleared by W1C as described above.
- Not defined: no sticky registers are built. Words 16..31 read 0 and writes to them are ignored.

## Structure
- Package opb_status_bank_pkg holds:
  - word-index constants: LIVE_BASE=0, STICKY_BASE=16, CTRL_IDX=32, CNT_BASE=48;
  - FREEZE bit position;
  - the ack-FSM state typedef.
- Sub-module status_bank_chan holds the LIVE, STICKY and CNT registers for one channel. It is instantiated C_NUM_CH times through a generate loop.
- The top level holds the address decode, ack FSM, CTRL register and read mux.

## Test plan
- Reset with all inputs active: every read returns 0, and Sl_xferAck pulses 1 cycle after each hit.
- user_valid[2] with data 0x0000ABCD, C_DATA_WIDTH=16, then read offset 0x08: Sl_DBus=0x0000ABCD, and CNT[2] at offset 0xC8 reads 1.
- Set FREEZE, pulse user_valid[0] with 0x55, read LIVE[0]: old value. CNT[0] has incremented. Clear FREEZE and pulse again: LIVE[0]=0x55.
- With sticky enabled: capture 0x0F, then 0xF0, and STICKY[0]=0xFF. Write 0x0F with BE=1111 to offset 0x40: reads 0xF0. A W1C in the same cycle as a capture of the same bit leaves it 1.
- 65536 pulses on user_valid[1]: CNT[1] wraps to 0.
- Read k=C_NUM_CH, write to offset 0xFC, and give an address outside the window. Required: reads return 0 with an ack, and no ack is given outside the window. A reset asserted in the ACK cycle clears Sl_xferAck with no clock edge.

Source files
------------

// File: rtl/opb_status_bank_pkg.sv
// Shared register-map constants, helpers and ack-FSM state type for opb_status_bank.
package opb_status_bank_pkg;

  localparam int unsigned LIVE_BASE   = 0;
  localparam int unsigned STICKY_BASE = 16;
  localparam int unsigned CTRL_IDX    = 32;
  localparam int unsigned CNT_BASE    = 48;
  localparam int unsigned FREEZE_BIT  = 0;
  localparam int unsigned CNT_WIDTH   = 16;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_BUSY = 1'b1
  } ack_state_e;

  // Expand a 4-bit byte-enable (bit b covers data bits [8b+7:8b]) into a bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/status_bank_chan.sv
// One status channel: LIVE capture, 16-bit update counter and, when
// STATUS_BANK_STICKY_EN is defined, a write-1-to-clear sticky register.
module status_bank_chan
  import opb_status_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  input  logic                  freeze,
  input  logic                  clr_en,
  input  logic [DATA_WIDTH-1:0] clr_mask,
  output logic [DATA_WIDTH-1:0] live,
  output logic [DATA_WIDTH-1:0] sticky,
  output logic [CNT_WIDTH-1:0]  cnt
);

  logic [DATA_WIDTH-1:0] live_q, live_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    live_d = live_q;
    cnt_d  = cnt_q;
    if (valid) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (!freeze) begin
        live_d = data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= '0;
      cnt_q  <= '0;
    end else begin
      live_q <= live_d;
      cnt_q  <= cnt_d;
    end
  end

  assign live = live_q;
  assign cnt  = cnt_q;

`ifdef STATUS_BANK_STICKY_EN
  logic [DATA_WIDTH-1:0] sticky_q, sticky_d;

  // Clear is applied before the set so fresh data always survives a same-cycle W1C.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_en) begin
      sticky_d = sticky_d & ~clr_mask;
    end
    if (valid) begin
      sticky_d = sticky_d | data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = ^{clr_en, clr_mask};
  assign sticky     = '0;
`endif

endmodule

// File: rtl/opb_status_bank.sv
// OPB slave exposing per-channel LIVE/STICKY/CNT status words plus a FREEZE control bit.
// Sticky registers are built only when STATUS_BANK_STICKY_EN is defined.
module opb_status_bank
  import opb_status_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01080100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010801FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 4,
  parameter int          C_DATA_WIDTH = 32
) (
  input  logic                           OPB_Clk,
  input  logic                           OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]        OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]      OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]        OPB_DBus,
  input  logic                           OPB_RNW,
  input  logic                           OPB_select,
  input  logic                           OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]        Sl_DBus,
  output logic                           Sl_xferAck,
  output logic                           Sl_errAck,
  output logic                           Sl_retry,
  output logic                           Sl_toutSup,
  input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
  input  logic [C_NUM_CH-1:0]            user_valid
);

  // OPB bit 0 is the MSB, so plain assignment yields conventional LSB-at-0 vectors.
  logic [31:0] addr, wdata, wmask, rdata;
  logic [3:0]  be;
  logic [5:0]  widx;
  logic        hit, wr_en;

  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be    = OPB_BE;
  assign widx  = addr[7:2];
  assign wmask = wdata & be_to_mask(be);
  assign hit   = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  ack_state_e        state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       dbus_q, dbus_d;
  logic              freeze_q, freeze_d;

  assign wr_en = (state_q == ACK_IDLE) && hit && !OPB_RNW;

  logic [C_DATA_WIDTH-1:0] live_all   [C_NUM_CH];
  logic [C_DATA_WIDTH-1:0] sticky_all [C_NUM_CH];
  logic [CNT_WIDTH-1:0]    cnt_all    [C_NUM_CH];

  for (genvar k = 0; k < C_NUM_CH; k++) begin : g_chan
    status_bank_chan #(
      .DATA_WIDTH (C_DATA_WIDTH)
    ) u_chan (
      .clk      (OPB_Clk),
      .rst_n    (OPB_Rst_n),
      .data_in  (user_data_in[k*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .valid    (user_valid[k]),
      .freeze   (freeze_q),
      .clr_en   (wr_en && (widx == 6'(STICKY_BASE + k))),
      .clr_mask (wmask[C_DATA_WIDTH-1:0]),
      .live     (live_all[k]),
      .sticky   (sticky_all[k]),
      .cnt      (cnt_all[k])
    );
  end

  always_comb begin
    freeze_d = freeze_q;
    if (wr_en && (widx == 6'(CTRL_IDX)) && be[FREEZE_BIT/8]) begin
      freeze_d = wdata[FREEZE_BIT];
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < C_NUM_CH; k++) begin
      if (widx == 6'(LIVE_BASE + k))   rdata = 32'(live_all[k]);
      if (widx == 6'(STICKY_BASE + k)) rdata = 32'(sticky_all[k]);
      if (widx == 6'(CNT_BASE + k))    rdata = 32'(cnt_all[k]);
    end
    if (widx == 6'(CTRL_IDX)) begin
      rdata[FREEZE_BIT] = freeze_q;
    end
  end

  // A hit seen while acknowledging is ignored, so each transfer takes two cycles.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dbus_d  = '0;
    if (state_q == ACK_IDLE) begin
      if (hit) begin
        state_d = ACK_BUSY;
        ack_d   = 1'b1;
        if (OPB_RNW) begin
          dbus_d = rdata;
        end
      end
    end else begin
      state_d = ACK_IDLE;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= ACK_IDLE;
      ack_q    <= 1'b0;
      dbus_q   <= '0;
      freeze_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dbus_q   <= dbus_d;
      freeze_q <= freeze_d;
    end
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, wmask};

endmodule

// File: tb/tb_opb_status_bank.sv
// Self-checking bench for opb_status_bank: vector table, directed corner cases,
// a counter wrap run and randomized traffic checked against a register-map model.
module tb_opb_status_bank;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam logic [31:0] BASE = 32'h01080100;
  localparam logic [31:0] HIGH = 32'h010801FF;
`ifdef STATUS_BANK_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:31]   abus;
  logic [0:3]    be;
  logic [0:31]   dbus_w;
  logic          rnw, sel, seq_addr;
  logic [0:31]   sl_dbus;
  logic          ack, err_ack, retry, tout_sup;
  logic [NCH*DW-1:0] udata;
  logic [NCH-1:0]    uvalid;

  int errors = 0;
  int checks = 0;

  int unsigned m_live[NCH], m_sticky[NCH], m_cnt[NCH];
  bit          m_freeze, m_ack;
  logic [31:0] m_dbus;

  opb_status_bank #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_NUM_CH     (NCH),
    .C_DATA_WIDTH (DW)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus_w),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq_addr),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (ack),
    .Sl_errAck    (err_ack),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout_sup),
    .user_data_in (udata),
    .user_valid   (uvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic [31:0] addr;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        exp_ack;
    logic [31:0] exp_dbus;
  } vec_t;

  vec_t tbl[$];

  task automatic addVec(input logic [3:0] v, input logic [15:0] d, input logic [31:0] a,
                        input logic r, input logic [3:0] b, input logic [31:0] w,
                        input logic ea, input logic [31:0] ed);
    vec_t t;
    t.valid = v; t.data = d; t.addr = a; t.rnw = r; t.be = b; t.wd = w;
    t.exp_ack = ea; t.exp_dbus = ed;
    tbl.push_back(t);
  endtask

  function automatic logic [31:0] model_read(input int unsigned w);
    if (w < NCH) return m_live[w];
    if (w >= 16 && w < 16 + NCH) return STK_EN ? m_sticky[w-16] : 32'd0;
    if (w == 32) return {31'b0, m_freeze};
    if (w >= 48 && w < 48 + NCH) return m_cnt[w-48];
    return 32'd0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NCH; k++) begin
      m_live[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0;
    end
    m_freeze = 0; m_ack = 0; m_dbus = '0;
  endtask

  task automatic busIdle();
    sel = 1'b0; abus = '0; rnw = 1'b1; be = '0; dbus_w = '0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic r, input logic [3:0] b,
                               input logic [31:0] w);
    sel = 1'b1; abus = a; rnw = r; be = b; dbus_w = w;
  endtask

  // Advance one clock; the model consumes the inputs currently on the pins.
  task automatic stepCycle();
    logic [31:0] a, wd, msk;
    logic [3:0]  bel;
    int unsigned w;
    bit hit, nack, nfreeze;
    a = abus; wd = dbus_w; bel = be; w = a[7:2];
    for (int b = 0; b < 4; b++) msk[b*8 +: 8] = {8{bel[b]}};
    hit  = sel && (a >= BASE) && (a <= HIGH);
    nack = !m_ack && hit;
    m_dbus = (nack && rnw) ? model_read(w) : 32'd0;
    nfreeze = m_freeze;
    if (nack && !rnw) begin
      if (w == 32 && bel[0]) nfreeze = wd[0];
      if (w >= 16 && w < 16 + NCH) m_sticky[w-16] = m_sticky[w-16] & ~(wd & msk) & 32'hFFFF;
    end
    for (int k = 0; k < NCH; k++) begin
      if (uvalid[k]) begin
        if (STK_EN) m_sticky[k] = m_sticky[k] | udata[k*DW +: DW];
        if (!m_freeze) m_live[k] = udata[k*DW +: DW];
        m_cnt[k] = (m_cnt[k] + 1) % 65536;
      end
    end
    m_freeze = nfreeze;
    m_ack = nack;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic exp_ack, input logic [31:0] exp_dbus);
    logic [31:0] got;
    got = sl_dbus;
    checks++;
    if (ack !== exp_ack || got !== exp_dbus) begin
      errors++;
      $display("[TB] FAIL %s: ack=%0b dbus=%h, expected ack=%0b dbus=%h",
               name, ack, got, exp_ack, exp_dbus);
    end
  endtask

  task automatic busXfer(input string name, input logic [31:0] a, input logic r,
                         input logic [3:0] b, input logic [31:0] w,
                         input logic ea, input logic [31:0] ed);
    applyStimulus(a, r, b, w);
    stepCycle();
    checkOutput(name, ea, ed);
    busIdle();
    stepCycle();
    checkOutput({name, "_drop"}, 1'b0, 32'd0);
  endtask

  initial begin
    seq_addr = 1'b0;
    modelReset();

    // Reset held with every input active.
    rst_n = 1'b0;
    applyStimulus(BASE, 1'b1, 4'hF, 32'hFFFF_FFFF);
    uvalid = '1;
    udata  = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    checkOutput("reset_hold0", 1'b0, 32'd0);
    @(negedge clk);
    checkOutput("reset_hold1", 1'b0, 32'd0);
    busIdle();
    uvalid = '0;
    udata  = '0;
    rst_n  = 1'b1;
    stepCycle();
    checkOutput("reset_release", 1'b0, 32'd0);

    addVec(4'b0100, 16'hABCD, BASE + 32'h08, 1, 4'hF, 0, 1, 32'h0000ABCD);
    addVec(4'b0000, 16'h0,    BASE + 32'hC8, 1, 4'hF, 0, 1, 32'd1);
    addVec(4'b0000, 16'h0,    BASE + 32'h00, 1, 4'hF, 0, 1, 32'd0);
    addVec(4'b0001, 16'h1234, BASE + 32'h80, 0, 4'hF, 1, 1, 32'd0);
    addVec(4'b0001, 16'h0055, BASE + 32'h00, 1, 4'hF, 0, 1, 32'h1234);
    addVec(4'b0000, 16'h0,    BASE + 32'hC0, 1, 4'hF, 0, 1, 32'd2);
    addVec(4'b0000, 16'h0,    BASE + 32'h80, 1, 4'hF, 0, 1, 32'd1);
    addVec(4'b0000, 16'h0,    BASE + 32'h80, 0, 4'h0, 0, 1, 32'd0);
    addVec(4'b0000, 16'h0,    BASE + 32'h80, 1, 4'hF, 0, 1, 32'd1);
    addVec(4'b0000, 16'h0,    BASE + 32'h80, 0, 4'b0001, 0, 1, 32'd0);
    addVec(4'b0001, 16'h0055, BASE + 32'h00, 1, 4'hF, 0, 1, 32'h55);
    addVec(4'b0000, 16'h0,    BASE + 32'h40, 1, 4'hF, 0, 1, STK_EN ? 32'h1275 : 32'd0);
    addVec(4'b0000, 16'h0,    BASE + 32'h48, 1, 4'hF, 0, 1, STK_EN ? 32'hABCD : 32'd0);
    addVec(4'b0000, 16'h0,    BASE + 32'h10, 1, 4'hF, 0, 1, 32'd0);
    addVec(4'b0000, 16'h0,    BASE + 32'hD0, 1, 4'hF, 0, 1, 32'd0);
    addVec(4'b0000, 16'h0,    BASE + 32'hFC, 0, 4'hF, 32'hDEADBEEF, 1, 32'd0);
    addVec(4'b0000, 16'h0,    BASE + 32'hFC, 1, 4'hF, 0, 1, 32'd0);
    addVec(4'b0000, 16'h0,    32'h010800FC,  1, 4'hF, 0, 0, 32'd0);
    addVec(4'b0000, 16'h0,    32'h01080200,  1, 4'hF, 0, 0, 32'd0);
    addVec(4'b1000, 16'h7E57, BASE + 32'h0C, 1, 4'hF, 0, 1, 32'h7E57);
    addVec(4'b0000, 16'h0,    BASE + 32'h0C, 0, 4'hF, 32'hFFFF, 1, 32'd0);
    addVec(4'b0000, 16'h0,    BASE + 32'h0C, 1, 4'hF, 0, 1, 32'h7E57);

    foreach (tbl[i]) begin
      uvalid = tbl[i].valid;
      udata  = {NCH{tbl[i].data}};
      busIdle();
      stepCycle();
      uvalid = '0;
      busXfer($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rnw, tbl[i].be, tbl[i].wd,
              tbl[i].exp_ack, tbl[i].exp_dbus);
    end

    // FREEZE written in the same cycle as a capture: that capture still lands.
    uvalid = 4'b1000;
    udata  = {NCH{16'h7777}};
    applyStimulus(BASE + 32'h80, 1'b0, 4'hF, 32'd1);
    stepCycle();
    checkOutput("frz_wr", 1'b1, 32'd0);
    busIdle();
    udata = {NCH{16'h8888}};
    stepCycle();
    checkOutput("frz_blocked_cap", 1'b0, 32'd0);
    uvalid = '0;
    busXfer("frz_live3", BASE + 32'h0C, 1'b1, 4'hF, 0, 1'b1, 32'h7777);
    busXfer("frz_clr", BASE + 32'h80, 1'b0, 4'hF, 0, 1'b1, 32'd0);

    // Sticky accumulate, W1C, same-cycle set/clear and byte-enable qualification on channel 1.
    uvalid = 4'b0010;
    udata  = {NCH{16'h000F}};
    stepCycle();
    udata  = {NCH{16'h00F0}};
    stepCycle();
    uvalid = '0;
    busXfer("stk_acc", BASE + 32'h44, 1'b1, 4'hF, 0, 1'b1, STK_EN ? 32'hFF : 32'd0);
    busXfer("stk_w1c", BASE + 32'h44, 1'b0, 4'hF, 32'h0F, 1'b1, 32'd0);
    busXfer("stk_after_w1c", BASE + 32'h44, 1'b1, 4'hF, 0, 1'b1, STK_EN ? 32'hF0 : 32'd0);
    uvalid = 4'b0010;
    udata  = {NCH{16'h0010}};
    applyStimulus(BASE + 32'h44, 1'b0, 4'hF, 32'hF0);
    stepCycle();
    checkOutput("stk_setclr_wr", 1'b1, 32'd0);
    uvalid = '0;
    busIdle();
    stepCycle();
    busXfer("stk_set_wins", BASE + 32'h44, 1'b1, 4'hF, 0, 1'b1, STK_EN ? 32'h10 : 32'd0);
    busXfer("stk_be_off", BASE + 32'h44, 1'b0, 4'b1110, 32'h10, 1'b1, 32'd0);
    busXfer("stk_be_kept", BASE + 32'h44, 1'b1, 4'hF, 0, 1'b1, STK_EN ? 32'h10 : 32'd0);
    busXfer("stk_be_on", BASE + 32'h44, 1'b0, 4'b0001, 32'h10, 1'b1, 32'd0);
    busXfer("stk_cleared", BASE + 32'h44, 1'b1, 4'hF, 0, 1'b1, 32'd0);

    // A hit held continuously is acknowledged every other cycle.
    applyStimulus(BASE + 32'hC4, 1'b1, 4'hF, 0);
    stepCycle();
    checkOutput("b2b_0", 1'b1, 32'd3);
    stepCycle();
    checkOutput("b2b_1", 1'b0, 32'd0);
    stepCycle();
    checkOutput("b2b_2", 1'b1, 32'd3);
    busIdle();
    stepCycle();

    // Drive CNT[1] up to the 16-bit wrap point.
    begin
      int unsigned n;
      n = 65536 - m_cnt[1];
      uvalid = 4'b0010;
      repeat (n) begin
        udata = {$urandom, $urandom};
        stepCycle();
      end
      uvalid = '0;
      busXfer("cnt_wrap", BASE + 32'hC4, 1'b1, 4'hF, 0, 1'b1, 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      uvalid = 4'($urandom);
      udata  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = 32'h01080000 + 32'($urandom_range(0, 1023));
        else a = BASE + 32'($urandom_range(0, 63) * 4);
        applyStimulus(a, 1'($urandom), 4'($urandom), $urandom);
      end else begin
        busIdle();
      end
      stepCycle();
      checkOutput($sformatf("rand%0d", i), m_ack, m_dbus);
    end
    uvalid = '0;
    busIdle();
    stepCycle();

    // Reset asserted while the ack is high drops it without a clock edge.
    applyStimulus(BASE + 32'h0C, 1'b1, 4'hF, 0);
    stepCycle();
    checkOutput("pre_rst_ack", 1'b1, m_dbus);
    busIdle();
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_mid_ack", 1'b0, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    busXfer("post_rst_live3", BASE + 32'h0C, 1'b1, 4'hF, 0, 1'b1, 32'd0);
    busXfer("post_rst_cnt0", BASE + 32'hC0, 1'b1, 4'hF, 0, 1'b1, 32'd0);
    busXfer("post_rst_ctrl", BASE + 32'h80, 1'b1, 4'hF, 0, 1'b1, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
